vga_text_buf: RTL

- Character-cell text buffer and cursor engine; sits directly upstream of the VGA character renderer.
- Accepts ASCII codes from the keyboard decoder and stores them in a COLS x ROWS character RAM.
- Serves the renderer's (scan_x, scan_y) character lookups and supplies cursor position and blink enable.
- Handles printable characters, Enter, Backspace, line wrap and whole-screen scroll.

---
 rtl/vga_text_pkg.sv | 25 ++
 rtl/text_ram.sv | 31 +++
 rtl/vga_text_buf.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text buffer: screen geometry,
// control character codes, the buffer FSM state encoding, and a printable
// character test.
package vga_text_pkg;

    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        SCROLL,
        CLEAR_ROW
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character RAM: FSM port A (independent read/write addresses), display port B read-only.
// Latency: 1 cycle on both read ports; writes land on the clock edge.
// Backpressure: none, both ports accept every cycle.
//
// Ports: clk; a_we/a_waddr/a_wdata write, a_raddr -> a_rdata read (FSM side);
//        b_addr -> b_rdata read (display side). Contents are not reset.
module text_ram #(
    parameter int DEPTH = 2100,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_waddr,
    input  logic [7:0]    a_wdata,
    input  logic [AW-1:0] a_raddr,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
        a_rdata <= mem[a_raddr];
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/vga_text_buf.sv
// Text buffer + cursor engine: stores keyboard ASCII in a COLS x ROWS RAM, serves renderer lookups.
// Latency: ram_ascii 1 cycle after scan_x/scan_y; cursor updates on the accepting edge.
// Backpressure: ready only in IDLE; strobes while busy (clear/scroll) are dropped, never buffered.
//
// Ports: clk, clrn (async active-low); ascii_in/ascii_valid/ready keyboard side;
//        scan_x/scan_y -> ram_ascii renderer lookup; cursor_x/cursor_y/blink_en cursor info.
module vga_text_buf #(
    parameter int COLS      = vga_text_pkg::COLS,
    parameter int ROWS      = vga_text_pkg::ROWS,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ready,
    input  logic [9:0] scan_x,
    input  logic [9:0] scan_y,
    output logic [7:0] ram_ascii,
    output logic [6:0] cursor_x,
    output logic [6:0] cursor_y,
    output logic       blink_en
);

    import vga_text_pkg::*;

    localparam int AW       = ADDR_W;
    localparam int CELLS    = COLS * ROWS;
    localparam int SCROLL_N = COLS * (ROWS - 1);
    localparam int BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [AW-1:0] LAST_CELL  = AW'(CELLS - 1);
    localparam logic [AW-1:0] SCROLL_END = AW'(SCROLL_N);
    localparam logic [AW-1:0] ROW_END    = AW'(COLS - 1);
    localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);
    localparam logic [6:0]    LAST_ROW   = 7'(ROWS - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [BW-1:0] blink_cnt;

    logic          a_we;
    logic [AW-1:0] a_waddr;
    logic [7:0]    a_wdata;
    logic [AW-1:0] a_raddr;
    logic [7:0]    a_rdata;
    logic [AW-1:0] b_addr;
    logic [7:0]    b_rdata;
    logic          rd_vld;

    logic          accept;
    logic          newline;
    logic [AW-1:0] cur_addr;

    assign ready    = (state == IDLE);
    assign accept   = ascii_valid && (state == IDLE);
    assign cur_addr = AW'(cursor_y) * AW'(COLS) + AW'(cursor_x);
    assign newline  = accept && ((is_printable(ascii_in) && cursor_x == LAST_COL) ||
                                 ascii_in == CHAR_CR);

    // RAM write/read port A control
    always_comb begin
        a_we    = 1'b0;
        a_waddr = cnt;
        a_wdata = CHAR_SPACE;
        // Scroll reads one row ahead; clamp once the source runs off the end.
        a_raddr = (cnt < SCROLL_END) ? cnt + AW'(COLS) : '0;
        case (state)
            CLEAR_ALL: begin
                a_we = 1'b1;
            end
            IDLE: begin
                if (accept && is_printable(ascii_in)) begin
                    a_we    = 1'b1;
                    a_waddr = cur_addr;
                    a_wdata = ascii_in;
                end else if (accept && ascii_in == CHAR_BS && cur_addr != '0) begin
                    // Stepping back from column 0 lands on the last column of the
                    // row above, which is also the linear address minus one.
                    a_we    = 1'b1;
                    a_waddr = cur_addr - AW'(1);
                end
            end
            SCROLL: begin
                // Data read in the previous cycle goes one row up.
                a_we    = (cnt != '0);
                a_waddr = cnt - AW'(1);
                a_wdata = a_rdata;
            end
            CLEAR_ROW: begin
                a_we    = 1'b1;
                a_waddr = SCROLL_END + cnt;
            end
            default: ;
        endcase
    end

    // Buffer FSM and cursor
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= CLEAR_ALL;
            cnt      <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            case (state)
                CLEAR_ALL: begin
                    if (cnt == LAST_CELL) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                IDLE: begin
                    if (newline) begin
                        cursor_x <= '0;
                        if (cursor_y != LAST_ROW) begin
                            cursor_y <= cursor_y + 7'd1;
                        end else begin
                            cnt   <= '0;
                            state <= SCROLL;
                        end
                    end else if (accept && is_printable(ascii_in)) begin
                        cursor_x <= cursor_x + 7'd1;
                    end else if (accept && ascii_in == CHAR_BS) begin
                        if (cursor_x != '0) begin
                            cursor_x <= cursor_x - 7'd1;
                        end else if (cursor_y != '0) begin
                            cursor_x <= LAST_COL;
                            cursor_y <= cursor_y - 7'd1;
                        end
                    end
                end
                SCROLL: begin
                    if (cnt == SCROLL_END) begin
                        cnt   <= '0;
                        state <= CLEAR_ROW;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                CLEAR_ROW: begin
                    if (cnt == ROW_END) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: state <= CLEAR_ALL;
            endcase
        end
    end

    // Display lookup: out-of-screen coordinates read as 8'h00.
    always_comb begin
        b_addr = '0;
        if (scan_x < 10'(COLS) && scan_y < 10'(ROWS)) begin
            b_addr = AW'(scan_y) * AW'(COLS) + AW'(scan_x);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= (scan_x < 10'(COLS)) && (scan_y < 10'(ROWS));
        end
    end

    assign ram_ascii = rd_vld ? b_rdata : 8'h00;

    // Cursor blink phase
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            blink_cnt <= '0;
            blink_en  <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_en  <= ~blink_en;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    text_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .a_we    (a_we),
        .a_waddr (a_waddr),
        .a_wdata (a_wdata),
        .a_raddr (a_raddr),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata)
    );

endmodule
